// File: rtl/alu_op_scheduler.sv
// Two-requester round-robin front end for the shared ALU units: latch one op, pulse the
// unit enable for one cycle, capture the registered unit result and return it with DONE.
module alu_op_scheduler #(
  parameter int WIDTH_A   = 8,
  parameter int WIDTH_B   = 8,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ0,
  input  logic                 REQ1,
  input  logic [3:0]           FUN0,
  input  logic [3:0]           FUN1,
  input  logic [WIDTH_A-1:0]   A0,
  input  logic [WIDTH_A-1:0]   A1,
  input  logic [WIDTH_B-1:0]   B0,
  input  logic [WIDTH_B-1:0]   B1,
  output logic                 GNT0,
  output logic                 GNT1,
  output logic                 DONE0,
  output logic                 DONE1,
  output logic [OUT_WIDTH-1:0] RESULT,
  output logic                 BUSY,
  output logic [WIDTH_A-1:0]   UNIT_A,
  output logic [WIDTH_B-1:0]   UNIT_B,
  output logic [1:0]           UNIT_FUN,
  output logic                 ARITH_EN,
  output logic                 LOGIC_EN,
  output logic                 CMP_EN,
  output logic                 SHIFT_EN,
  input  logic [OUT_WIDTH-1:0] ARITH_OUT,
  input  logic [OUT_WIDTH-1:0] LOGIC_OUT,
  input  logic [OUT_WIDTH-1:0] CMP_OUT,
  input  logic [OUT_WIDTH-1:0] SHIFT_OUT
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 prio;
  logic                 owner;
  logic [1:0]           unit_sel;
  logic                 take;
  logic                 pick;
  logic [OUT_WIDTH-1:0] unit_res;

  // GNT and the enables come only from registered state, never from REQ/FUN.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    pick      = 1'b0;
    GNT0      = 1'b0;
    GNT1      = 1'b0;
    ARITH_EN  = 1'b0;
    LOGIC_EN  = 1'b0;
    CMP_EN    = 1'b0;
    SHIFT_EN  = 1'b0;
    BUSY      = (state != IDLE);
    case (state)
      IDLE: begin
        if (REQ0 || REQ1) begin
          take      = 1'b1;
          pick      = (REQ0 && REQ1) ? prio : REQ1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        GNT0 = ~owner;
        GNT1 = owner;
        case (unit_sel)
          2'b00:   ARITH_EN = 1'b1;
          2'b01:   LOGIC_EN = 1'b1;
          2'b10:   CMP_EN   = 1'b1;
          default: SHIFT_EN = 1'b1;
        endcase
        state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    unit_res = ARITH_OUT;
    case (unit_sel)
      2'b00:   unit_res = ARITH_OUT;
      2'b01:   unit_res = LOGIC_OUT;
      2'b10:   unit_res = CMP_OUT;
      default: unit_res = SHIFT_OUT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      prio     <= 1'b0;
      owner    <= 1'b0;
      unit_sel <= 2'b00;
      UNIT_A   <= '0;
      UNIT_B   <= '0;
      UNIT_FUN <= 2'b00;
      RESULT   <= '0;
      DONE0    <= 1'b0;
      DONE1    <= 1'b0;
    end else begin
      state <= state_nxt;
      DONE0 <= 1'b0;
      DONE1 <= 1'b0;
      if (take) begin
        UNIT_A   <= pick ? A1 : A0;
        UNIT_B   <= pick ? B1 : B0;
        UNIT_FUN <= pick ? FUN1[1:0] : FUN0[1:0];
        unit_sel <= pick ? FUN1[3:2] : FUN0[3:2];
        owner    <= pick;
        prio     <= ~pick;
      end
      if (state == CAPTURE) begin
        RESULT <= unit_res;
        DONE0  <= ~owner;
        DONE1  <= owner;
      end
    end
  end

endmodule
